image_output_framer: RTL
========================

# image_output_framer

Receive-side companion to `image_processor`. It consumes the raw `out_pixel` stream produced on each `shift_en` cycle and discards the pipeline-fill samples. It tags the remaining WIDTH×HEIGHT pixels with frame/line markers, optionally zeroes border pixels, and presents them through a small FIFO with a valid/ready handshake, so downstream logic no longer needs the bench-style "dump every cycle" capture.

## Interface
- `WIDTH`, 100, pixels per line.
- `HEIGHT`, 100, lines per frame.
- `DATA_WIDTH`, 8, bits per colour channel; pixel word is 3*DATA_WIDTH.
- `LATENCY`, WIDTH+2, number of `shift_en` samples discarded after `frame_start` (pipeline fill).
- `FIFO_DEPTH`, 16, output FIFO entries; power of two, ≥2.
- `BORDER_ZERO`, 1, 1 = force pixels in row 0, row HEIGHT-1, col 0 and col WIDTH-1 to zero.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `frame_start` in 1: one-cycle pulse that starts or restarts frame capture.
- `shift_en` in 1: same strobe that drives `image_processor`; a sample is valid this cycle.
- `in_pixel` in 3*DATA_WIDTH: `out_pixel` from `image_processor`.
- `m_valid` out 1: FIFO head valid.
- `m_ready` in 1: downstream accepts the head this cycle.
- `m_data` out 3*DATA_WIDTH: head pixel.
- `m_sof` out 1, `m_eol` out 1, `m_eof` out 1: head tags (first pixel, last pixel of line, last pixel of frame).
- `overflow` out 1: sticky; a pixel was dropped on a full FIFO.
- `busy` out 1: state ≠ IDLE.
- `frame_done` out 1: one-cycle pulse after the last frame pixel is counted.

## Operation
- States are IDLE, FILL, STREAM.
  - IDLE: `shift_en` ignored. `frame_start` → FILL.
  - FILL: each `shift_en` increments the fill counter and the sample is discarded. When the LATENCY-th sample is accepted → STREAM. If LATENCY=0, `frame_start` goes directly to STREAM.
  - STREAM: each `shift_en` produces one frame pixel at (row, col) and advances col. At col=WIDTH-1, col wraps to 0 and row increments. The pixel at (HEIGHT-1, WIDTH-1) pulses `frame_done` and returns to IDLE.
- `frame_start` in any state, including coincident with `shift_en`:
  - Clears the fill, row and col counters and clears `overflow`, then enters FILL.
  - A `shift_en` in the same cycle is treated as the first FILL sample.
  - FIFO contents are retained and keep draining.
- Pixel write:
  - Data = `in_pixel`, or 0 if BORDER_ZERO and the pixel is on the border.
  - Tags: sof = (row 0, col 0); eol = (col WIDTH-1); eof = (row HEIGHT-1, col WIDTH-1).
- FIFO:
  - `m_valid` = count≠0. `m_data` and tags show the head entry; tags read 0 when `m_valid`=0.
  - Read when `m_valid && m_ready`.
  - Write accepted if count<FIFO_DEPTH, or if a read occurs in the same cycle.
  - Otherwise the pixel is dropped and `overflow` is set. Row/col still advance, so geometry stays aligned.
  - Pointers wrap modulo FIFO_DEPTH.
- Counter widths: $clog2 of WIDTH, HEIGHT and LATENCY+1, each at least 1 bit.

## Timing
- Reset (async assert, sync-safe deassert):
  - State=IDLE; counters=0; FIFO empty.
  - `m_valid`=0, `m_data`=0, tags=0, `overflow`=0, `busy`=0, `frame_done`=0.
- Reset mid-frame drops all FIFO contents and all in-progress state.
- Latency: a pixel accepted at edge N appears with `m_valid`=1 after edge N when the FIFO was empty. Throughput is one pixel per cycle.
- `frame_done` is high for exactly the cycle after the edge that accepted the eof pixel. `busy` falls on that same edge.
- `m_data` must hold stable while `m_valid && !m_ready`.

## Test plan
Common parameters: WIDTH=4, HEIGHT=3, LATENCY=5, FIFO_DEPTH=4, BORDER_ZERO=1.

1. `frame_start`, then 17 back-to-back `shift_en` with `in_pixel`=0..16, `m_ready`=1. Required: exactly 12 outputs; all are 0 except output 5 = 10 and output 6 = 11.
2. Same stimulus as 1, checking tags: `m_sof` on output 0; `m_eol` on outputs 3, 7, 11; `m_eof` only on output 11; `frame_done` pulses once, one cycle after the 17th accept; `busy` falls with it.
3. Same stimulus as 1 with `m_ready`=0 until the 11th frame pixel, then 1. Required: outputs are frame pixels 0–3 then 10–11; `overflow`=1 from the first drop; `m_data` is stable while stalled.
4. `shift_en` asserted every other cycle with the same data as 1. Required: output sequence identical to scenario 1.
5. `rst_n` pulsed low after 8 accepted samples. Required: immediately `m_valid`=0, `busy`=0, `overflow`=0; rerunning scenario 1 then gives an identical result.
6. `frame_start` reasserted after 9 samples with `m_ready`=0. Required: the 4 queued pixels remain; the counter restart discards the next 5 samples; `overflow` cleared.

Source files
------------

// File: rtl/image_output_framer.sv
// Frames the raw image_processor pixel stream: drops pipeline-fill samples, tags SOF/EOL/EOF,
// optionally zeroes border pixels, and queues pixels in a small valid/ready FIFO.
module image_output_framer #(
  parameter int WIDTH       = 100,
  parameter int HEIGHT      = 100,
  parameter int DATA_WIDTH  = 8,
  parameter int LATENCY     = WIDTH + 2,
  parameter int FIFO_DEPTH  = 16,
  parameter bit BORDER_ZERO = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    frame_start,
  input  logic                    shift_en,
  input  logic [3*DATA_WIDTH-1:0] in_pixel,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [3*DATA_WIDTH-1:0] m_data,
  output logic                    m_sof,
  output logic                    m_eol,
  output logic                    m_eof,
  output logic                    overflow,
  output logic                    busy,
  output logic                    frame_done
);

  localparam int PW = 3 * DATA_WIDTH;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int FW = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [CW-1:0] LAST_COL  = CW'(WIDTH - 1);
  localparam logic [RW-1:0] LAST_ROW  = RW'(HEIGHT - 1);
  localparam logic [FW-1:0] LAST_FILL = FW'((LATENCY > 0) ? LATENCY - 1 : 0);
  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, FILL, STREAM} state_t;

  typedef struct packed {
    logic [PW-1:0] dat;
    logic          sof;
    logic          eol;
    logic          eof;
  } ent_t;

  state_t        state_q;
  logic [FW-1:0] fill_q;
  logic [RW-1:0] row_q;
  logic [CW-1:0] col_q;
  logic          overflow_q;
  logic          frame_done_q;

  ent_t          mem [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q, cnt_d;

  logic last_col, last_row, border, pix_vld, rd, wr;
  ent_t wr_ent, head;

  assign last_col = (col_q == LAST_COL);
  assign last_row = (row_q == LAST_ROW);
  assign border   = (row_q == '0) || last_row || (col_q == '0) || last_col;

  // frame_start wins over a coincident stream sample: the counters restart instead.
  assign pix_vld = (state_q == STREAM) && shift_en && !frame_start;
  assign rd      = (cnt_q != '0) && m_ready;
  assign wr      = pix_vld && ((cnt_q != FULL_CNT) || rd);

  always_comb begin
    wr_ent     = '0;
    wr_ent.dat = (BORDER_ZERO && border) ? '0 : in_pixel;
    wr_ent.sof = (row_q == '0) && (col_q == '0);
    wr_ent.eol = last_col;
    wr_ent.eof = last_row && last_col;
  end

  always_comb begin
    cnt_d = cnt_q + {{AW{1'b0}}, wr} - {{AW{1'b0}}, rd};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      fill_q       <= '0;
      row_q        <= '0;
      col_q        <= '0;
      overflow_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (frame_start) begin
        row_q      <= '0;
        col_q      <= '0;
        fill_q     <= '0;
        overflow_q <= 1'b0;
        if (LATENCY == 0) begin
          state_q <= STREAM;
        end else if (shift_en && (LATENCY == 1)) begin
          state_q <= STREAM;
        end else begin
          state_q <= FILL;
          if (shift_en) fill_q <= FW'(1);
        end
      end else begin
        case (state_q)
          FILL: begin
            if (shift_en) begin
              if (fill_q == LAST_FILL) begin
                state_q <= STREAM;
                fill_q  <= '0;
              end else begin
                fill_q <= fill_q + FW'(1);
              end
            end
          end
          STREAM: begin
            if (shift_en) begin
              // Geometry advances even for dropped pixels so tags stay aligned.
              if (!wr) overflow_q <= 1'b1;
              if (last_col) begin
                col_q <= '0;
                if (last_row) begin
                  row_q        <= '0;
                  state_q      <= IDLE;
                  frame_done_q <= 1'b1;
                end else begin
                  row_q <= row_q + RW'(1);
                end
              end else begin
                col_q <= col_q + CW'(1);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr) wptr_q <= wptr_q + AW'(1);
      if (rd) rptr_q <= rptr_q + AW'(1);
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wptr_q] <= wr_ent;
  end

  assign head       = mem[rptr_q];
  assign m_valid    = (cnt_q != '0);
  assign m_data     = m_valid ? head.dat : '0;
  assign m_sof      = m_valid & head.sof;
  assign m_eol      = m_valid & head.eol;
  assign m_eof      = m_valid & head.eof;
  assign overflow   = overflow_q;
  assign busy       = (state_q != IDLE);
  assign frame_done = frame_done_q;

endmodule
